// File: rtl/led_pkg.sv
// Shared definitions for the LED brightness path: breath FSM state encoding,
// default duty width and a counter-width helper.
package led_pkg;

  localparam int LED_DUTY_W = 8;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RISE    = 3'd1,
    ST_HOLD_HI = 3'd2,
    ST_FALL    = 3'd3,
    ST_HOLD_LO = 3'd4
  } breath_state_t;

  // Width of a counter that must hold 0..n-1; never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Modulo-CYCLES counter producing one tick per CYCLES un-stalled run cycles.
// A stalled cycle freezes the count, so back-pressure delays ticks without
// dropping or merging any of them.
module tick_prescaler
  import led_pkg::*;
#(
  parameter int CYCLES = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  input  logic clear,
  input  logic stall,
  output logic tick
);

  localparam int CW = cnt_width(CYCLES);
  localparam logic [CW-1:0] LAST = CW'(CYCLES - 1);

  logic [CW-1:0] pcnt_reg;

  assign tick = run && !stall && (pcnt_reg == LAST);

  // Count only while running and not stalled; clear forces the count home.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pcnt_reg <= '0;
    end else if (clear) begin
      pcnt_reg <= '0;
    end else if (run && !stall) begin
      pcnt_reg <= (pcnt_reg == LAST) ? '0 : pcnt_reg + CW'(1);
    end
  end

endmodule

// File: rtl/breath_ramp.sv
// Breathing brightness generator: ramps duty 0..MAX, holds, ramps back to 0,
// holds, and repeats. Each new level is offered downstream over valid/ready
// and stays stable until accepted.
module breath_ramp
  import led_pkg::*;
#(
  parameter int WIDTH       = LED_DUTY_W,
  parameter int STEP_CYCLES = 4,
  parameter int HOLD_STEPS  = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             duty_ready,
  output logic [WIDTH-1:0] duty,
  output logic             duty_valid,
  output logic [2:0]       phase,
  output logic             cycle_done
);

  localparam logic [WIDTH-1:0] MAX   = '1;
  localparam int               HW    = cnt_width(HOLD_STEPS);
  localparam logic [HW-1:0]    HLAST = HW'(HOLD_STEPS - 1);

  breath_state_t    state_reg, state_next;
  logic [WIDTH-1:0] level_reg, level_next;
  logic             valid_reg, valid_next;
  logic [HW-1:0]    hcnt_reg, hcnt_next;
  logic             done_reg, done_next;

  logic             stall;
  logic             xfer;
  logic             tick;
  logic             run;
  logic             clear;
  logic [WIDTH-1:0] level_inc;
  logic [WIDTH-1:0] level_dec;

  assign stall     = valid_reg && !duty_ready;
  assign xfer      = valid_reg && duty_ready;
  assign run       = (state_reg != ST_IDLE);
  // The prescaler sits at zero in IDLE and is cleared on the way there.
  assign clear     = (state_reg == ST_IDLE) || (!en && !stall);
  assign level_inc = level_reg + WIDTH'(1);
  assign level_dec = level_reg - WIDTH'(1);

  tick_prescaler #(
    .CYCLES (STEP_CYCLES)
  ) u_prescaler (
    .clk   (clk),
    .rst_n (rst_n),
    .run   (run),
    .clear (clear),
    .stall (stall),
    .tick  (tick)
  );

  // Next-state, next-level and handshake decisions for the breath sequence.
  always_comb begin
    state_next = state_reg;
    level_next = level_reg;
    valid_next = valid_reg;
    hcnt_next  = hcnt_reg;
    done_next  = 1'b0;

    // An accepted level retires; a tick on the same edge may re-raise valid.
    if (xfer) begin
      valid_next = 1'b0;
    end

    if (state_reg == ST_IDLE) begin
      // Start always restarts from level 0, offered without waiting a step.
      if (en) begin
        state_next = ST_RISE;
        level_next = '0;
        valid_next = 1'b1;
        hcnt_next  = '0;
      end
    end else if (!en) begin
      // Let a pending level drain before parking; no new emissions.
      if (!stall) begin
        state_next = ST_IDLE;
      end
    end else if (tick) begin
      case (state_reg)
        ST_RISE: begin
          level_next = level_inc;
          valid_next = 1'b1;
          if (level_inc == MAX) begin
            state_next = ST_HOLD_HI;
            hcnt_next  = '0;
          end
        end
        ST_HOLD_HI: begin
          if (hcnt_reg == HLAST) begin
            state_next = ST_FALL;
          end else begin
            hcnt_next = hcnt_reg + HW'(1);
          end
        end
        ST_FALL: begin
          level_next = level_dec;
          valid_next = 1'b1;
          if (level_dec == '0) begin
            state_next = ST_HOLD_LO;
            hcnt_next  = '0;
          end
        end
        ST_HOLD_LO: begin
          if (hcnt_reg == HLAST) begin
            state_next = ST_RISE;
            done_next  = 1'b1;
          end else begin
            hcnt_next = hcnt_reg + HW'(1);
          end
        end
        default: begin
          state_next = ST_IDLE;
        end
      endcase
    end
  end

  // State, level and handshake registers; reset drops any pending offer.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= ST_IDLE;
      level_reg <= '0;
      valid_reg <= 1'b0;
      hcnt_reg  <= '0;
      done_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      level_reg <= level_next;
      valid_reg <= valid_next;
      hcnt_reg  <= hcnt_next;
      done_reg  <= done_next;
    end
  end

  assign duty       = level_reg;
  assign duty_valid = valid_reg;
  assign phase      = state_reg;
  assign cycle_done = done_reg;

endmodule
